serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 131 +++++++++++++
 tb/tb_serial_frame_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - hunts for a sync pattern on a serial stream and assembles the next W bits into a word.
// Optional even-parity bit after the data word is enabled by defining FRAME_PARITY_EN.
module serial_frame_rx #(
    parameter int                 W      = 8,
    parameter int                 SYNC_W = 4,
    parameter logic [SYNC_W-1:0]  SYNC   = 4'b1011
) (
    input  logic         C,
    input  logic         R,
    input  logic         D,
    input  logic         EN,
    output logic [W-1:0] Q,
    output logic         V,
    output logic         LOCK,
    output logic         ERR
);
    localparam int CW = $clog2(W + 1);

`ifdef FRAME_PARITY_EN
    typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {HUNT, DATA} state_t;
`endif

    state_t              state, state_n;
    logic [SYNC_W-1:0]   win, win_n, win_shift;
    logic [W-1:0]        sh, sh_n, sh_shift;
    logic [CW-1:0]       cnt, cnt_n;
    logic [W-1:0]        q_n;
    logic                v_n;
`ifdef FRAME_PARITY_EN
    logic                err_q, err_n;
`endif

    assign win_shift = {win[SYNC_W-2:0], D};

    generate
        if (W == 1) begin : g_sh1
            assign sh_shift = D;
        end else begin : g_shn
            assign sh_shift = {sh[W-2:0], D};
        end
    endgenerate

    always_ff @(posedge C) begin
        if (R) begin
            state <= HUNT;
            win   <= '0;
            sh    <= '0;
            cnt   <= '0;
            Q     <= '0;
            V     <= 1'b0;
`ifdef FRAME_PARITY_EN
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            win   <= win_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            Q     <= q_n;
            V     <= v_n;
`ifdef FRAME_PARITY_EN
            err_q <= err_n;
`endif
        end
    end

    // Nothing advances without EN; V and ERR fall back to 0 so they stay single-cycle pulses.
    always_comb begin
        state_n = state;
        win_n   = win;
        sh_n    = sh;
        cnt_n   = cnt;
        q_n     = Q;
        v_n     = 1'b0;
`ifdef FRAME_PARITY_EN
        err_n   = 1'b0;
`endif
        if (EN) begin
            case (state)
                HUNT: begin
                    win_n = win_shift;
                    if (win_shift == SYNC) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    sh_n  = sh_shift;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
`ifdef FRAME_PARITY_EN
                        state_n = PAR;
`else
                        q_n     = sh_shift;
                        v_n     = 1'b1;
                        state_n = HUNT;
                        win_n   = '0;
`endif
                    end
                end
`ifdef FRAME_PARITY_EN
                PAR: begin
                    if (^{sh, D}) begin
                        err_n = 1'b1;
                    end else begin
                        q_n = sh;
                        v_n = 1'b1;
                    end
                    state_n = HUNT;
                    win_n   = '0;
                end
`endif
                default: begin
                    state_n = HUNT;
                    win_n   = '0;
                end
            endcase
        end
    end

    assign LOCK = (state != HUNT);

`ifdef FRAME_PARITY_EN
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - table-driven bench for serial_frame_rx (W=8, SYNC=1011).
module tb_serial_frame_rx;
    logic       C, R, D, EN;
    logic [7:0] Q;
    logic       V, LOCK, ERR;

    serial_frame_rx #(.W(8), .SYNC_W(4), .SYNC(4'b1011)) dut (
        .C(C), .R(R), .D(D), .EN(EN), .Q(Q), .V(V), .LOCK(LOCK), .ERR(ERR)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

`ifdef FRAME_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct {
        bit       r, en, d;
        bit [7:0] q;
        bit       v, lock, err;
    } vec_t;

    vec_t     vecs[$];
    int       total = 0;
    int       bad   = 0;
    bit [3:0] sync_pat = 4'b1011;

    task automatic add(input bit r, input bit en, input bit d,
                       input bit [7:0] q, input bit v, input bit lock, input bit err);
        vec_t e;
        e.r = r; e.en = en; e.d = d; e.q = q; e.v = v; e.lock = lock; e.err = err;
        vecs.push_back(e);
    endtask

    // Expected-row builder for one full frame: sync, word, optional parity bit.
    task automatic add_frame(input bit [7:0] w, input bit [7:0] qprev,
                             input bit gaps, input bit badpar);
        bit fin;
        for (int i = 3; i >= 0; i--) begin
            add(0, 1, sync_pat[i], qprev, 0, i == 0, 0);
            if (gaps) add(0, 0, 1'($urandom), qprev, 0, i == 0, 0);
        end
        for (int i = 7; i >= 0; i--) begin
            fin = (i == 0) && !PAR_ON;
            add(0, 1, w[i], fin ? w : qprev, fin, !fin, 0);
            if (gaps) add(0, 0, 1'($urandom), fin ? w : qprev, 0, !fin, 0);
        end
        if (PAR_ON) begin
            add(0, 1, (^w) ^ badpar, badpar ? qprev : w, !badpar, 0, badpar);
            if (gaps) add(0, 0, 1'($urandom), badpar ? qprev : w, 0, 0, 0);
        end
    endtask

    task automatic apply(input int idx);
        vec_t e;
        e = vecs[idx];
        R = e.r; EN = e.en; D = e.d;
        @(posedge C);
        #1;
        total++;
        if (Q !== e.q || V !== e.v || LOCK !== e.lock || ERR !== e.err) begin
            bad++;
            $display("FAIL row%0d: got Q=%h V=%b LOCK=%b ERR=%b, want Q=%h V=%b LOCK=%b ERR=%b",
                     idx, Q, V, LOCK, ERR, e.q, e.v, e.lock, e.err);
        end
    endtask

    int vcount;

    initial begin
        R = 1'b1; EN = 1'b0; D = 1'b0;

        // reset, with EN/D active to show reset priority
        add(1, 0, 0, 8'h00, 0, 0, 0);
        add(1, 1, 1, 8'h00, 0, 0, 0);
        // basic frame
        add_frame(8'hA5, 8'h00, 0, 0);
        add(0, 0, 1, 8'hA5, 0, 0, 0);
        // same frame with EN gaps and random D while EN=0
        add_frame(8'hA5, 8'hA5, 1, 0);
        // false start then overlapping sync: 1,0,1,0,1,1 detects on 6th bit
        add(0, 1, 1, 8'hA5, 0, 0, 0);
        add(0, 1, 0, 8'hA5, 0, 0, 0);
        add(0, 1, 1, 8'hA5, 0, 0, 0);
        add(0, 1, 0, 8'hA5, 0, 0, 0);
        add(0, 1, 1, 8'hA5, 0, 0, 0);
        add(0, 1, 1, 8'hA5, 0, 1, 0);
        for (int i = 7; i >= 0; i--) begin
            bit [7:0] w3c;
            bit       fin;
            w3c = 8'h3C;
            fin = (i == 0) && !PAR_ON;
            add(0, 1, w3c[i], fin ? 8'h3C : 8'hA5, fin, !fin, 0);
        end
        if (PAR_ON) add(0, 1, 1'b0, 8'h3C, 1, 0, 0);
        // data containing 1011, then a partial sync: no second V
        add_frame(8'hB0, 8'h3C, 0, 0);
        add(0, 1, 1, 8'hB0, 0, 0, 0);
        add(0, 1, 0, 8'hB0, 0, 0, 0);
        add(0, 1, 1, 8'hB0, 0, 0, 0);
        add(0, 1, 0, 8'hB0, 0, 0, 0);
        add(0, 0, 0, 8'hB0, 0, 0, 0);
        // reset mid-frame after 4 data bits; window was cleared by the reset too
        add(1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 3; i >= 0; i--) add(0, 1, sync_pat[i], 8'h00, 0, i == 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0);
        add(0, 1, 1, 8'h00, 0, 1, 0);
        add(0, 1, 1, 8'h00, 0, 1, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0);
        add(1, 1, 1, 8'h00, 0, 0, 0);
        add_frame(8'h5A, 8'h00, 0, 0);
        // back-to-back frames
        add_frame(8'h01, 8'h5A, 0, 0);
        add_frame(8'hFE, 8'h01, 0, 0);
        if (PAR_ON) begin
            add_frame(8'hA5, 8'hFE, 0, 0);
            add_frame(8'h07, 8'hA5, 0, 1);
        end
        add(0, 0, 0, PAR_ON ? 8'hA5 : 8'hFE, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(i);

        // hand sequence: EN held low with D toggling must never produce V or LOCK
        R = 1'b0; EN = 1'b0;
        vcount = 0;
        for (int i = 0; i < 16; i++) begin
            D = i[0];
            @(posedge C);
            #1;
            if (V || LOCK) vcount++;
        end
        total++;
        if (vcount != 0) begin
            bad++;
            $display("FAIL en_low_idle: got %0d V/LOCK cycles, want 0", vcount);
        end

        // hand sequence: one frame, count V pulses over a long tail
        vcount = 0;
        EN = 1'b1;
        for (int i = 0; i < 12 + (PAR_ON ? 1 : 0) + 10; i++) begin
            if (i < 4)       D = sync_pat[3 - i];
            else if (i < 12) D = (i % 2 == 0);
            else if (i == 12 && PAR_ON) D = 1'b0;
            else             D = 1'b0;
            @(posedge C);
            #1;
            if (V) vcount++;
        end
        total++;
        if (vcount != 1 || Q !== 8'hAA) begin
            bad++;
            $display("FAIL single_pulse: got %0d pulses Q=%h, want 1 pulse Q=aa", vcount, Q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
